// File: rtl/trap_controller.sv
// Trap/mret sequencer: writes mepc/mcause/mtval/mstatus one CSR per cycle, then redirects fetch (IRQ entry under TRAP_IRQ_EN).
// Latency: trap = accept + 5 cycles (redirect in the 5th), mret = accept + 2 cycles (redirect in the 2nd).
// Backpressure: stall held from accept until back in IDLE; requests arriving while busy are dropped.
module trap_controller #(
  parameter logic [1:0] MPP_VALUE = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        illegal_instr,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_inst,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic [31:0] mstatus_in,
`ifdef TRAP_IRQ_EN
  input  logic        irq_ext,
  input  logic [31:0] irq_pc,
`endif
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT, R_STATUS
  } state_t;

  typedef enum logic [1:0] {C_ILL, C_EBRK, C_ECALL, C_IRQ} cause_t;

  state_t      state;
  cause_t      lat_cause;
  logic        lat_mret;
  logic [31:0] lat_pc;
  logic [31:0] lat_inst;
  logic        req_acc;
  logic        take;
  logic        mret_only;
  logic [31:0] status_trap;
  logic [31:0] status_mret;

  assign req_acc   = (state == IDLE) & req_valid & (ecall | ebreak | mret | illegal_instr);
  assign mret_only = mret & ~illegal_instr & ~ebreak & ~ecall;

`ifdef TRAP_IRQ_EN
  logic irq_acc;
  // A committing synchronous request always pre-empts the interrupt.
  assign irq_acc = (state == IDLE) & irq_ext & mstatus_in[3] & ~req_acc;
  assign take    = req_acc | irq_acc;
`else
  assign take    = req_acc;
`endif

  assign busy  = (state != IDLE);
  assign stall = take | busy;
  assign flush = take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cause <= C_ILL;
      lat_mret  <= 1'b0;
      lat_pc    <= 32'd0;
      lat_inst  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_acc) begin
            lat_pc   <= req_pc;
            lat_inst <= req_inst;
            lat_mret <= mret_only;
            if (illegal_instr)  lat_cause <= C_ILL;
            else if (ebreak)    lat_cause <= C_EBRK;
            else                lat_cause <= C_ECALL;
            state <= mret_only ? R_STATUS : W_EPC;
          end
`ifdef TRAP_IRQ_EN
          else if (irq_acc) begin
            lat_pc    <= irq_pc;
            lat_inst  <= 32'd0;
            lat_mret  <= 1'b0;
            lat_cause <= C_IRQ;
            state     <= W_EPC;
          end
`endif
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_TVAL;
        W_TVAL:   state <= W_STATUS;
        W_STATUS: state <= REDIRECT;
        R_STATUS: state <= REDIRECT;
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // mstatus is read live so any CSR write landing before this state is seen.
  always_comb begin
    status_trap        = mstatus_in;
    status_trap[7]     = mstatus_in[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = MPP_VALUE;
    status_mret        = mstatus_in;
    status_mret[3]     = mstatus_in[7];
    status_mret[7]     = 1'b1;
  end

  always_comb begin
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (state)
      W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = lat_pc & 32'hFFFF_FFFC;
      end
      W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h342;
        case (lat_cause)
          C_ILL:   csr_wdata = 32'd2;
          C_EBRK:  csr_wdata = 32'd3;
          C_ECALL: csr_wdata = 32'd11;
          default: csr_wdata = 32'h8000_000B;
        endcase
      end
      W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h343;
        case (lat_cause)
          C_ILL:   csr_wdata = lat_inst;
          C_EBRK:  csr_wdata = lat_pc;
          default: csr_wdata = 32'd0;
        endcase
      end
      W_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = status_trap;
      end
      R_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = status_mret;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = lat_mret ? mepc_in : (mtvec_in & 32'hFFFF_FFFC);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed + randomized bench for trap_controller against a per-transaction reference model.
module tb_trap_controller;

  localparam logic [1:0] MPP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, ecall, ebreak, mret, illegal_instr;
  logic [31:0] req_pc, req_inst, mtvec_in, mepc_in, mstatus_in;
  logic        irq_ext;
  logic [31:0] irq_pc;
  logic        csr_we, stall, flush, redirect_valid, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  trap_controller #(.MPP_VALUE(MPP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .ecall(ecall), .ebreak(ebreak), .mret(mret),
    .illegal_instr(illegal_instr), .req_pc(req_pc), .req_inst(req_inst),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in), .mstatus_in(mstatus_in),
`ifdef TRAP_IRQ_EN
    .irq_ext(irq_ext), .irq_pc(irq_pc),
`endif
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always @(negedge clk) begin
    if (csr_we) wr_cnt++;
    if (redirect_valid) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules for the mstatus images.
  function automatic logic [31:0] trap_status(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | ({31'd0, ms[3]} << 7) | ({30'd0, MPP} << 11);
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] ms);
    return (ms & ~32'h0000_0088) | ({31'd0, ms[7]} << 3) | 32'h80;
  endfunction

  task automatic rand_csr();
    mtvec_in   = $urandom;
    mepc_in    = $urandom;
    mstatus_in = $urandom;
  endtask

  task automatic clear_req();
    req_valid = 0; ecall = 0; ebreak = 0; mret = 0; illegal_instr = 0;
    irq_ext = 0;
  endtask

  // kind: 0 none, 1 illegal, 2 ebreak, 3 ecall, 4 mret, 5 interrupt
  task automatic run_req(input logic v, input logic e, input logic b, input logic m,
                         input logic il, input logic [31:0] pc, input logic [31:0] inst,
                         input bit rnd_csr, input bit noise);
    int kind, len;
    logic [31:0] lpc, linst, cause, e_addr, e_data, e_rpc;
    logic e_we, e_rv;
    req_valid = v; ecall = e; ebreak = b; mret = m; illegal_instr = il;
    req_pc = pc; req_inst = inst;
    if (rnd_csr) rand_csr();
    #1;
    if (v && il)      kind = 1;
    else if (v && b)  kind = 2;
    else if (v && e)  kind = 3;
    else if (v && m)  kind = 4;
    else if (irq_ext && mstatus_in[3]) kind = 5;
    else              kind = 0;
    lpc   = (kind == 5) ? irq_pc : pc;
    linst = inst;
    cause = (kind == 1) ? 32'd2 : (kind == 2) ? 32'd3 : (kind == 3) ? 32'd11 : 32'h8000_000B;
    chk("accept_stall", stall, kind != 0);
    chk("accept_flush", flush, kind != 0);
    chk("accept_busy", busy, 0);
    chk("accept_we", csr_we, 0);
    len = (kind == 0) ? 0 : (kind == 4) ? 2 : 5;
    @(posedge clk); #1;
    for (int k = 0; k < len; k++) begin
      req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ecall = 1'($urandom_range(0, 1)); ebreak = 1'($urandom_range(0, 1));
      mret = 1'($urandom_range(0, 1)); illegal_instr = 1'($urandom_range(0, 1));
      irq_ext = 0;
      req_pc = $urandom; req_inst = $urandom;
      if (rnd_csr) rand_csr();
      #1;
      e_we = 1; e_rv = 0; e_addr = 0; e_data = 0; e_rpc = 0;
      if (kind == 4) begin
        if (k == 0) begin e_addr = 32'h300; e_data = mret_status(mstatus_in); end
        else begin e_we = 0; e_rv = 1; e_rpc = mepc_in; end
      end else begin
        case (k)
          0: begin e_addr = 32'h341; e_data = lpc & 32'hFFFF_FFFC; end
          1: begin e_addr = 32'h342; e_data = cause; end
          2: begin e_addr = 32'h343;
                   e_data = (kind == 1) ? linst : (kind == 2) ? lpc : 32'd0; end
          3: begin e_addr = 32'h300; e_data = trap_status(mstatus_in); end
          default: begin e_we = 0; e_rv = 1; e_rpc = mtvec_in & 32'hFFFF_FFFC; end
        endcase
      end
      chk("seq_busy", busy, 1);
      chk("seq_stall", stall, 1);
      chk("seq_flush", flush, 0);
      chk("seq_we", csr_we, e_we);
      if (e_we) begin
        chk("seq_waddr", csr_waddr, e_addr);
        chk("seq_wdata", csr_wdata, e_data);
      end
      chk("seq_redirect", redirect_valid, e_rv);
      if (e_rv) chk("seq_redirect_pc", redirect_pc, e_rpc);
      @(posedge clk); #1;
    end
    clear_req();
    #1;
    chk("end_busy", busy, 0);
    chk("end_stall", stall, 0);
    chk("end_we", csr_we, 0);
    chk("end_redirect", redirect_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    rst_n = 0;
    clear_req();
    req_pc = 0; req_inst = 0; irq_pc = 0;
    mtvec_in = 0; mepc_in = 0; mstatus_in = 0;
    #12;
    chk("rst_we", csr_we, 0);
    chk("rst_waddr", csr_waddr, 0);
    chk("rst_wdata", csr_wdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // ecall basic
    mtvec_in = 32'h200; mstatus_in = 32'h8; mepc_in = 0;
    run_req(1, 1, 0, 0, 0, 32'h100, 32'h0000_0073, 0, 0);
    // illegal wins over ecall
    run_req(1, 1, 0, 0, 1, 32'h104, 32'hFFFF_FFFF, 0, 0);
    // ebreak, unaligned pc: mepc aligned, mtval keeps full pc
    mtvec_in = 32'h0000_0403;
    run_req(1, 0, 1, 1, 0, 32'h0000_1236, 32'h0010_0073, 0, 0);
    // mret
    mepc_in = 32'h104; mstatus_in = 32'h80;
    run_req(1, 0, 0, 1, 0, 32'h300, 32'h3020_0073, 0, 0);
    // valid without flags is not accepted
    run_req(1, 0, 0, 0, 0, 32'h500, 32'h0, 0, 0);

    // requests arriving while busy are dropped
    mtvec_in = 32'h200; mstatus_in = 32'h8;
    w0 = wr_cnt; r0 = rd_cnt;
    run_req(1, 1, 0, 0, 0, 32'h100, 32'h0, 0, 1);
    chk("busy_write_count", wr_cnt - w0, 4);
    chk("busy_redirect_count", rd_cnt - r0, 1);

    // reset during W_TVAL abandons the sequence
    req_valid = 1; ecall = 1; req_pc = 32'h180;
    @(posedge clk); #1;
    clear_req();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_waddr", csr_waddr, 32'h343);
    rst_n = 0;
    #1;
    w0 = wr_cnt; r0 = rd_cnt;
    chk("mid_rst_we", csr_we, 0);
    chk("mid_rst_redirect", redirect_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", stall, 0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_writes", wr_cnt - w0, 0);
    chk("post_rst_redirects", rd_cnt - r0, 0);
    run_req(1, 1, 0, 0, 0, 32'h240, 32'h0, 0, 0);

`ifdef TRAP_IRQ_EN
    irq_pc = 32'h300; mstatus_in = 32'h8; mtvec_in = 32'h200;
    irq_ext = 1;
    run_req(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    irq_ext = 1; mstatus_in = 32'h0;
    run_req(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    irq_ext = 1; mstatus_in = 32'h8;
    run_req(1, 1, 0, 0, 0, 32'h700, 32'h0, 0, 0);
`endif

    // randomized transactions with live-changing CSR inputs and busy-time noise
    for (int i = 0; i < 60; i++) begin
      run_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), $urandom, $urandom, 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
